// File: rtl/timer_pkg.sv
// Shared types and constants for the five-digit BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam int NUM_DIGITS = 5;
  localparam int DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Non-decimal nibbles (A..F) saturate to 9 so the count is always valid BCD.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/timer_countdown_ctrl_bcd_dec_digit.sv
// One BCD digit of the decrement chain: subtracts the incoming borrow and
// passes a borrow upward when the digit wraps from 0 to 9.
module bcd_dec_digit
  import timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               borrow,
  output logic [DIGIT_W-1:0] digit_next,
  output logic               borrow_next
);

  logic [DIGIT_W-1:0] clamped;

  always_comb begin
    clamped     = clamp_digit(digit);
    digit_next  = clamped;
    borrow_next = 1'b0;
    if (borrow) begin
      if (clamped == '0) begin
        digit_next  = BCD_MAX;
        borrow_next = 1'b1;
      end else begin
        digit_next = clamped - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_countdown_ctrl.sv
// Five-digit BCD countdown controller: holds the count, decrements it once per
// prescaled tick, and feeds digit values plus visibility flags to the decoders.
module timer_countdown_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            load_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   value_i,
  input  logic                            start_i,
  input  logic                            stop_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   digits_o,
  output logic [NUM_DIGITS-1:0]           show_o,
  output logic                            running_o,
  output logic                            done_o
);

  localparam int COUNT_W = NUM_DIGITS * DIGIT_W;
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  state_t              state, state_next;
  logic [COUNT_W-1:0]  count, count_next;
  logic [TICK_W-1:0]   prescale, prescale_next;
  logic [BLINK_W-1:0]  blink_cnt, blink_cnt_next;
  logic                blink_on, blink_on_next;

  logic                tick;
  logic                underflow;
  logic [COUNT_W-1:0]  dec_count;

  assign tick = (state == RUN) && (prescale == TICK_LAST);

  // Ripple-borrow decrement chain; each stage owns its borrow wire.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic borrow_prev;
    logic borrow_next;
    if (k == 0) begin : g_first
      assign borrow_prev = tick;
    end else begin : g_rest
      assign borrow_prev = g_digit[k-1].borrow_next;
    end
    bcd_dec_digit u_digit (
      .digit       (count[k*DIGIT_W +: DIGIT_W]),
      .borrow      (borrow_prev),
      .digit_next  (dec_count[k*DIGIT_W +: DIGIT_W]),
      .borrow_next (borrow_next)
    );
  end

  assign underflow = g_digit[NUM_DIGITS-1].borrow_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      count     <= '0;
      prescale  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      state     <= state_next;
      count     <= count_next;
      prescale  <= prescale_next;
      blink_cnt <= blink_cnt_next;
      blink_on  <= blink_on_next;
    end
  end

  // Every RUN edge advances the prescaler, including one that samples stop_i,
  // so a pause/resume cycle neither loses nor gains prescaler steps.
  always_comb begin
    state_next     = state;
    count_next     = count;
    prescale_next  = prescale;
    blink_cnt_next = blink_cnt;
    blink_on_next  = blink_on;

    if (load_i) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        count_next[k*DIGIT_W +: DIGIT_W] = clamp_digit(value_i[k*DIGIT_W +: DIGIT_W]);
      end
      prescale_next  = '0;
      blink_cnt_next = '0;
      blink_on_next  = 1'b1;
      state_next     = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && (count != '0)) begin
            state_next    = RUN;
            prescale_next = '0;
          end
        end
        RUN: begin
          prescale_next = (prescale == TICK_LAST) ? '0 : prescale + TICK_W'(1);
          if (tick && !underflow) begin
            count_next = dec_count;
          end
          if (tick && !underflow && (dec_count == '0)) begin
            state_next     = DONE;
            blink_cnt_next = '0;
            blink_on_next  = 1'b1;
          end else if (stop_i) begin
            state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (start_i) begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (stop_i) begin
            state_next     = IDLE;
            blink_cnt_next = '0;
            blink_on_next  = 1'b1;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_next = '0;
            blink_on_next  = ~blink_on;
          end else begin
            blink_cnt_next = blink_cnt + BLINK_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Leading-zero blanking scans from the most significant digit downward.
  always_comb begin
    logic any_nonzero;
    any_nonzero = 1'b0;
    show_o      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      any_nonzero = any_nonzero | (count[k*DIGIT_W +: DIGIT_W] != '0);
      show_o[k]   = any_nonzero || (k == 0);
    end
    if ((state == DONE) && !blink_on) begin
      show_o = '0;
    end
  end

  assign digits_o  = count;
  assign running_o = (state == RUN);
  assign done_o    = (state == DONE);

endmodule

// File: tb/tb_timer_countdown_ctrl.sv
// Directed self-checking bench for timer_countdown_ctrl with TICK_DIV=4, BLINK_DIV=3.
module tb_timer_countdown_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [19:0] value;
  logic        start;
  logic        stop;
  logic [19:0] digits;
  logic [4:0]  show;
  logic        running;
  logic        done;

  int tests_run    = 0;
  int tests_failed = 0;

  timer_countdown_ctrl #(
    .TICK_DIV  (4),
    .BLINK_DIV (3)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (load),
    .value_i   (value),
    .start_i   (start),
    .stop_i    (stop),
    .digits_o  (digits),
    .show_o    (show),
    .running_o (running),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and park 1 ns after the last one for sampling.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load(input logic [19:0] v);
    value = v;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    tests_run++; if (digits !== 20'h00000) begin tests_failed++; $display("[TB] FAIL reset_digits got=%h want=%h", digits, 20'h00000); end
    tests_run++; if (show !== 5'b00001) begin tests_failed++; $display("[TB] FAIL reset_show got=%b want=%b", show, 5'b00001); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_running got=%b want=0", running); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    pulse_start();
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_start_zero running got=%b want=0", running); end
  endtask

  task automatic test_countdown();
    pulse_load(20'h00012);
    tests_run++; if (digits !== 20'h00012) begin tests_failed++; $display("[TB] FAIL load_12 got=%h want=%h", digits, 20'h00012); end
    tests_run++; if (show !== 5'b00011) begin tests_failed++; $display("[TB] FAIL load_12_show got=%b want=%b", show, 5'b00011); end
    pulse_start();
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_running got=%b want=1", running); end
    step(3);
    tests_run++; if (digits !== 20'h00012) begin tests_failed++; $display("[TB] FAIL pre_tick got=%h want=%h", digits, 20'h00012); end
    step(1);
    tests_run++; if (digits !== 20'h00011) begin tests_failed++; $display("[TB] FAIL tick_n4 got=%h want=%h", digits, 20'h00011); end
    step(4);
    tests_run++; if (digits !== 20'h00010) begin tests_failed++; $display("[TB] FAIL tick_n8 got=%h want=%h", digits, 20'h00010); end
    step(4);
    tests_run++; if (digits !== 20'h00009) begin tests_failed++; $display("[TB] FAIL tick_n12 got=%h want=%h", digits, 20'h00009); end
    tests_run++; if (show !== 5'b00001) begin tests_failed++; $display("[TB] FAIL tick_n12_show got=%b want=%b", show, 5'b00001); end
    step(32);
    tests_run++; if (digits !== 20'h00001) begin tests_failed++; $display("[TB] FAIL tick_n44 got=%h want=%h", digits, 20'h00001); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_early got=%b want=0", done); end
    step(4);
    tests_run++; if (digits !== 20'h00000) begin tests_failed++; $display("[TB] FAIL tick_n48 got=%h want=%h", digits, 20'h00000); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL done_n48 got=%b want=1", done); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL running_n48 got=%b want=0", running); end
  endtask

  // Continues from the DONE entry edge left by test_countdown.
  task automatic test_blink();
    tests_run++; if (show !== 5'b00001) begin tests_failed++; $display("[TB] FAIL blink_e0 got=%b want=%b", show, 5'b00001); end
    step(2);
    tests_run++; if (show !== 5'b00001) begin tests_failed++; $display("[TB] FAIL blink_e2 got=%b want=%b", show, 5'b00001); end
    step(1);
    tests_run++; if (show !== 5'b00000) begin tests_failed++; $display("[TB] FAIL blink_e3 got=%b want=%b", show, 5'b00000); end
    step(2);
    tests_run++; if (show !== 5'b00000) begin tests_failed++; $display("[TB] FAIL blink_e5 got=%b want=%b", show, 5'b00000); end
    step(1);
    tests_run++; if (show !== 5'b00001) begin tests_failed++; $display("[TB] FAIL blink_e6 got=%b want=%b", show, 5'b00001); end
    pulse_start();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL done_start_ignored got=%b want=1", done); end
    step(2);
    tests_run++; if (show !== 5'b00000) begin tests_failed++; $display("[TB] FAIL blink_e9 got=%b want=%b", show, 5'b00000); end
    pulse_stop();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL ack_done got=%b want=0", done); end
    tests_run++; if (show !== 5'b00001) begin tests_failed++; $display("[TB] FAIL ack_show got=%b want=%b", show, 5'b00001); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL ack_running got=%b want=0", running); end
  endtask

  task automatic test_borrow();
    pulse_load(20'h10000);
    tests_run++; if (show !== 5'b11111) begin tests_failed++; $display("[TB] FAIL borrow_load_show got=%b want=%b", show, 5'b11111); end
    pulse_start();
    step(4);
    tests_run++; if (digits !== 20'h09999) begin tests_failed++; $display("[TB] FAIL borrow_digits got=%h want=%h", digits, 20'h09999); end
    tests_run++; if (show !== 5'b01111) begin tests_failed++; $display("[TB] FAIL borrow_show got=%b want=%b", show, 5'b01111); end
    pulse_load(20'h00000);
  endtask

  task automatic test_pause_resume();
    pulse_load(20'h00005);
    pulse_start();
    step(1);
    pulse_stop();
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL pause_running got=%b want=0", running); end
    step(10);
    tests_run++; if (digits !== 20'h00005) begin tests_failed++; $display("[TB] FAIL pause_hold got=%h want=%h", digits, 20'h00005); end
    pulse_start();
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("[TB] FAIL resume_running got=%b want=1", running); end
    step(1);
    tests_run++; if (digits !== 20'h00005) begin tests_failed++; $display("[TB] FAIL resume_r1 got=%h want=%h", digits, 20'h00005); end
    step(1);
    tests_run++; if (digits !== 20'h00004) begin tests_failed++; $display("[TB] FAIL resume_r2 got=%h want=%h", digits, 20'h00004); end
    pulse_load(20'h00000);
  endtask

  task automatic test_priority_clamp();
    pulse_load(20'h00003);
    pulse_start();
    value = 20'hF3A21;
    load  = 1'b1;
    stop  = 1'b1;
    start = 1'b1;
    step(1);
    load  = 1'b0;
    stop  = 1'b0;
    start = 1'b0;
    tests_run++; if (digits !== 20'h93921) begin tests_failed++; $display("[TB] FAIL clamp_digits got=%h want=%h", digits, 20'h93921); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL priority_running got=%b want=0", running); end
    tests_run++; if (show !== 5'b11111) begin tests_failed++; $display("[TB] FAIL clamp_show got=%b want=%b", show, 5'b11111); end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_start_running got=%b want=1", running); end
    step(5);
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (digits !== 20'h00000) begin tests_failed++; $display("[TB] FAIL async_rst_digits got=%h want=%h", digits, 20'h00000); end
    tests_run++; if (show !== 5'b00001) begin tests_failed++; $display("[TB] FAIL async_rst_show got=%b want=%b", show, 5'b00001); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_rst_running got=%b want=0", running); end
    step(1);
    rst = 1'b0;
    step(2);
    tests_run++; if (digits !== 20'h00000) begin tests_failed++; $display("[TB] FAIL post_rst_digits got=%h want=%h", digits, 20'h00000); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_rst_done got=%b want=0", done); end
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    value = 20'h00000;
    test_reset();
    test_countdown();
    test_blink();
    test_borrow();
    test_pause_resume();
    test_priority_clamp();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
